// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding,
// read-owner codes and the {valid, owner} tag carried alongside each read.
package mem_arbiter_pkg;

    localparam int MEM_LATENCY_DEF = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT_I = 3'd1,
        GRANT_D = 3'd2,
        DRAIN_I = 3'd3,
        DRAIN_D = 3'd4,
        WRITE   = 3'd5
    } arb_state_e;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
    } tag_t;

endpackage

// File: rtl/arb_tag_pipe.sv
// Read-owner shift register: one {valid, owner} entry per memory latency
// cycle, so the oldest entry lines up with the returning data word.
module arb_tag_pipe
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = MEM_LATENCY_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  tag_t tag_i,
    output tag_t oldest_o,
    output logic any_valid_o
);

    tag_t stage_q [DEPTH];

    // Advance every entry by one stage each cycle; reset forgets in-flight reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int k = 1; k < DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    // Pipeline occupancy, used to decide when a drain has completed.
    always_comb begin
        any_valid_o = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            any_valid_o = any_valid_o | stage_q[k].valid;
        end
    end

    assign oldest_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the I-cache and D-cache fill FSMs and D-cache write-through
// onto one pipelined memory, routing returned read data to its owner.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icache_req,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              dcache_req,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_data_valid,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              icache_stall,
    output logic              dcache_stall,
    output logic              icache_data_valid,
    output logic              dcache_data_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              wr_ack
);

    arb_state_e state_q, state_d;
    logic       last_d_q, last_d_d;
    tag_t       tag_ins_s, tag_old_s;
    logic       any_valid_s;

    assign tag_ins_s.valid = mem_enable & ~mem_wr;
    assign tag_ins_s.owner = (state_q == GRANT_D) ? OWN_D : OWN_I;

    arb_tag_pipe #(
        .DEPTH (MEM_LATENCY)
    ) u_tag_pipe (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .tag_i       (tag_ins_s),
        .oldest_o    (tag_old_s),
        .any_valid_o (any_valid_s)
    );

    // Arbitration FSM: next state plus the memory-side drive for this cycle.
    always_comb begin
        state_d    = state_q;
        last_d_d   = last_d_q;
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        wr_ack     = 1'b0;
        case (state_q)
            IDLE: begin
                // last_d_q lets a waiting I-cache in after a completed D fill.
                if (wr_req) begin
                    state_d = WRITE;
                end else if (dcache_req && !(icache_req && last_d_q)) begin
                    state_d = GRANT_D;
                end else if (icache_req) begin
                    state_d  = GRANT_I;
                    last_d_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT_I: begin
                if (icache_req) begin
                    mem_enable = 1'b1;
                    mem_addr   = icache_addr;
                end else begin
                    state_d = DRAIN_I;
                end
            end
            GRANT_D: begin
                if (dcache_req) begin
                    mem_enable = 1'b1;
                    mem_addr   = dcache_addr;
                end else begin
                    state_d = DRAIN_D;
                end
            end
            DRAIN_I: begin
                if (!any_valid_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN_I;
                end
            end
            DRAIN_D: begin
                if (!any_valid_s) begin
                    state_d  = IDLE;
                    last_d_d = 1'b1;
                end else begin
                    state_d = DRAIN_D;
                end
            end
            WRITE: begin
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = wr_addr;
                mem_wdata  = wr_data;
                wr_ack     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and fairness flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    // Stalls are masked by rst_n so every control output is low during reset.
    assign icache_stall      = rst_n & icache_req & (state_q != GRANT_I);
    assign dcache_stall      = rst_n & dcache_req & (state_q != GRANT_D);
    assign icache_data_valid = mem_data_valid & tag_old_s.valid & (tag_old_s.owner == OWN_I);
    assign dcache_data_valid = mem_data_valid & tag_old_s.valid & (tag_old_s.owner == OWN_D);
    assign rdata             = mem_rdata;

endmodule
